// File: rtl/fifo_crossbar_scheduler.sv
// fifo_crossbar_scheduler: three 4-deep show-ahead byte FIFOs feeding a 3x3 round-robin crossbar.
// Latency: a byte written at edge N is on result/en after edge N+1 (2 cycles from the write strobe).
// Backpressure: none toward writers; a write to a full FIFO is dropped unless its head pops at the same edge.

// Small 4-entry show-ahead FIFO; the head reads 0 while empty.
module xbar_fifo4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_wrreq,
  input  logic [7:0] i_din,
  input  logic       i_rdreq,
  output logic [7:0] o_q,
  output logic       o_empty,
  output logic       o_full,
  output logic [1:0] o_usedw
);
  logic [7:0] r_mem [0:3];
  logic [1:0] r_rd_ptr;
  logic [1:0] r_wr_ptr;
  logic [2:0] r_count;
  logic       w_pop;
  logic       w_push;

  // A pop on an empty FIFO is ignored; a write to a full FIFO only lands if a pop frees the slot.
  assign w_pop   = i_rdreq && (r_count != 3'd0);
  assign w_push  = i_wrreq && ((r_count != 3'd4) || w_pop);
  assign o_empty = (r_count == 3'd0);
  assign o_full  = (r_count == 3'd4);
  assign o_usedw = r_count[1:0];
  assign o_q     = o_empty ? 8'h00 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; reset flushes every queued entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= 2'd0;
      r_wr_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  end
endmodule

module fifo_crossbar_scheduler (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] din1,
  input  logic [7:0] din2,
  input  logic [7:0] din3,
  input  logic       wrreq1,
  input  logic       wrreq2,
  input  logic       wrreq3,
  input  logic [7:0] data0,
  output logic       full1,
  output logic       full2,
  output logic       full3,
  output logic       empty1,
  output logic       empty2,
  output logic       empty3,
  output logic [1:0] usedw1,
  output logic [1:0] usedw2,
  output logic [1:0] usedw3,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic       rdreq1,
  output logic       rdreq2,
  output logic       rdreq3,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic [1:0] sel3,
  output logic [7:0] result1,
  output logic [7:0] result2,
  output logic [7:0] result3,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  output logic [7:0] hex1,
  output logic [7:0] hex2,
  output logic [7:0] hex3,
  output logic [7:0] hex4,
  output logic [7:0] hex5,
  output logic [7:0] hex6
);
  logic [7:0] w_head   [1:3];
  logic [3:1] w_empty;
  logic [3:1] w_rdreq;
  logic [2:0] w_cand   [1:3];
  logic [1:0] w_gnt    [1:3];
  logic [7:0] w_mux    [1:3];
  logic [1:0] r_rr     [1:3];
  logic [7:0] r_result [1:3];
  logic [3:1] r_en;

  // First candidate at or after the pointer, scanning 1->2->3->1; 0 when nobody qualifies.
  function automatic logic [1:0] rr_pick(input logic [1:0] rr, input logic [2:0] cand);
    logic [1:0] p;
    rr_pick = 2'd0;
    p = rr;
    for (int k = 0; k < 3; k++) begin
      if ((rr_pick == 2'd0) && cand[p - 2'd1]) rr_pick = p;
      p = (p == 2'd3) ? 2'd1 : p + 2'd1;
    end
  endfunction

  // Active-low segment code, decimal point held off.
  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 8'hC0;  4'h1: seg7 = 8'hF9;  4'h2: seg7 = 8'hA4;  4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;  4'h5: seg7 = 8'h92;  4'h6: seg7 = 8'h82;  4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;  4'h9: seg7 = 8'h90;  4'hA: seg7 = 8'h88;  4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;  4'hD: seg7 = 8'hA1;  4'hE: seg7 = 8'h86;  default: seg7 = 8'h8E;
    endcase
  endfunction

  xbar_fifo4 u_fifo1 (.clk(clk), .reset(reset), .i_wrreq(wrreq1), .i_din(din1), .i_rdreq(w_rdreq[1]),
                      .o_q(w_head[1]), .o_empty(w_empty[1]), .o_full(full1), .o_usedw(usedw1));
  xbar_fifo4 u_fifo2 (.clk(clk), .reset(reset), .i_wrreq(wrreq2), .i_din(din2), .i_rdreq(w_rdreq[2]),
                      .o_q(w_head[2]), .o_empty(w_empty[2]), .o_full(full2), .o_usedw(usedw2));
  xbar_fifo4 u_fifo3 (.clk(clk), .reset(reset), .i_wrreq(wrreq3), .i_din(din3), .i_rdreq(w_rdreq[3]),
                      .o_q(w_head[3]), .o_empty(w_empty[3]), .o_full(full3), .o_usedw(usedw3));

  // Candidate mask per output: bit i-1 set when input i holds a head addressed to that output.
  always_comb begin
    w_cand = '{default: 3'b000};
    for (int o = 1; o <= 3; o++) begin
      for (int i = 1; i <= 3; i++) begin
        w_cand[o][i-1] = !w_empty[i] && (w_head[i][7:6] == 2'(o));
      end
    end
  end

  assign w_gnt[1] = rr_pick(r_rr[1], w_cand[1]);
  assign w_gnt[2] = rr_pick(r_rr[2], w_cand[2]);
  assign w_gnt[3] = rr_pick(r_rr[3], w_cand[3]);

  // Pop granted heads and discard-addressed heads; each head names one output, so one grant at most.
  always_comb begin
    w_rdreq = 3'b000;
    for (int i = 1; i <= 3; i++) begin
      w_rdreq[i] = !w_empty[i] && ((w_head[i][7:6] == 2'd0) || (w_gnt[1] == 2'(i)) ||
                                   (w_gnt[2] == 2'(i)) || (w_gnt[3] == 2'(i)));
    end
  end

  // Per-output 4:1 mux; select 0 falls back to the idle value.
  always_comb begin
    w_mux = '{default: 8'h00};
    for (int o = 1; o <= 3; o++) begin
      case (w_gnt[o])
        2'd1:    w_mux[o] = w_head[1];
        2'd2:    w_mux[o] = w_head[2];
        2'd3:    w_mux[o] = w_head[3];
        default: w_mux[o] = data0;
      endcase
    end
  end

  // Capture delivered bytes and advance each pointer past its winner; reset drops in-flight pops.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 1; o <= 3; o++) begin
        r_rr[o]     <= 2'd1;
        r_result[o] <= 8'h00;
      end
      r_en <= 3'b000;
    end else begin
      for (int o = 1; o <= 3; o++) begin
        r_en[o] <= (w_gnt[o] != 2'd0);
        if (w_gnt[o] != 2'd0) begin
          r_result[o] <= w_mux[o];
          r_rr[o]     <= (w_gnt[o] == 2'd3) ? 2'd1 : w_gnt[o] + 2'd1;
        end
      end
    end
  end

  assign empty1  = w_empty[1];
  assign empty2  = w_empty[2];
  assign empty3  = w_empty[3];
  assign data1   = w_head[1];
  assign data2   = w_head[2];
  assign data3   = w_head[3];
  assign rdreq1  = w_rdreq[1];
  assign rdreq2  = w_rdreq[2];
  assign rdreq3  = w_rdreq[3];
  assign sel1    = w_gnt[1];
  assign sel2    = w_gnt[2];
  assign sel3    = w_gnt[3];
  assign result1 = r_result[1];
  assign result2 = r_result[2];
  assign result3 = r_result[3];
  assign en1     = r_en[1];
  assign en2     = r_en[2];
  assign en3     = r_en[3];
  assign hex1    = seg7(r_result[1][3:0]);
  assign hex2    = seg7(r_result[1][7:4]);
  assign hex3    = seg7(r_result[2][3:0]);
  assign hex4    = seg7(r_result[2][7:4]);
  assign hex5    = seg7(r_result[3][3:0]);
  assign hex6    = seg7(r_result[3][7:4]);
endmodule

// File: tb/tb_fifo_crossbar_scheduler.sv
// Bench for fifo_crossbar_scheduler: directed vector table, hand sequences, random traffic.
// Reference model keeps each input FIFO as a queue and each output pointer as an integer.
// Inputs are driven 1ns after the rising edge; outputs are sampled away from the edge.
`timescale 1ns/1ps
module tb_fifo_crossbar_scheduler;
  logic       clk;
  logic       reset;
  logic [7:0] din1, din2, din3, data0;
  logic       wrreq1, wrreq2, wrreq3;
  logic       full1, full2, full3, empty1, empty2, empty3;
  logic [1:0] usedw1, usedw2, usedw3, sel1, sel2, sel3;
  logic [7:0] data1, data2, data3, result1, result2, result3;
  logic       rdreq1, rdreq2, rdreq3, en1, en2, en3;
  logic [7:0] hex1, hex2, hex3, hex4, hex5, hex6;

  fifo_crossbar_scheduler dut (
    .clk(clk), .reset(reset), .din1(din1), .din2(din2), .din3(din3),
    .wrreq1(wrreq1), .wrreq2(wrreq2), .wrreq3(wrreq3), .data0(data0),
    .full1(full1), .full2(full2), .full3(full3),
    .empty1(empty1), .empty2(empty2), .empty3(empty3),
    .usedw1(usedw1), .usedw2(usedw2), .usedw3(usedw3),
    .data1(data1), .data2(data2), .data3(data3),
    .rdreq1(rdreq1), .rdreq2(rdreq2), .rdreq3(rdreq3),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .result1(result1), .result2(result2), .result3(result3),
    .en1(en1), .en2(en2), .en3(en3),
    .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5), .hex6(hex6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT outputs gathered into arrays (index 0 = port 1).
  logic       t_empty [3];
  logic       t_full  [3];
  logic [1:0] t_usedw [3];
  logic [7:0] t_data  [3];
  logic       t_rdreq [3];
  logic [1:0] t_sel   [3];
  logic [7:0] t_res   [3];
  logic       t_en    [3];
  logic [7:0] t_hex   [6];
  assign t_empty = '{empty1, empty2, empty3};
  assign t_full  = '{full1, full2, full3};
  assign t_usedw = '{usedw1, usedw2, usedw3};
  assign t_data  = '{data1, data2, data3};
  assign t_rdreq = '{rdreq1, rdreq2, rdreq3};
  assign t_sel   = '{sel1, sel2, sel3};
  assign t_res   = '{result1, result2, result3};
  assign t_en    = '{en1, en2, en3};
  assign t_hex   = '{hex1, hex2, hex3, hex4, hex5, hex6};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: FIFO contents as queues, pointers as 1..3, delivered bytes and valids.
  logic [7:0] mq [3][$];
  int         m_rr  [3];
  logic [7:0] m_res [3];
  logic       m_en  [3];

  // Scoreboard for the fill-to-full sequence.
  bit sb_on = 1'b0;
  int acc_cnt [256];
  int n_del3 = 0;
  bit saw_full1 = 1'b0;
  bit saw_full2 = 1'b0;

  function automatic logic [7:0] seg(input logic [3:0] v);
    case (v)
      4'h0: seg = 8'hC0;  4'h1: seg = 8'hF9;  4'h2: seg = 8'hA4;  4'h3: seg = 8'hB0;
      4'h4: seg = 8'h99;  4'h5: seg = 8'h92;  4'h6: seg = 8'h82;  4'h7: seg = 8'hF8;
      4'h8: seg = 8'h80;  4'h9: seg = 8'h90;  4'hA: seg = 8'h88;  4'hB: seg = 8'h83;
      4'hC: seg = 8'hC6;  4'hD: seg = 8'hA1;  4'hE: seg = 8'h86;  default: seg = 8'h8E;
    endcase
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      m_rr[i]  = 1;
      m_res[i] = 8'h00;
      m_en[i]  = 1'b0;
    end
  endtask

  // One clock cycle: drive, check combinational view against the model, clock, check registers.
  task automatic cyc(input logic rst, input logic [2:0] w, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] c, input logic [7:0] z);
    logic [7:0] din [3];
    logic [7:0] head [3];
    logic       ne [3];
    int         g [3];
    logic       pop [3];
    logic       acc;
    din = '{a, b, c};
    reset = rst; data0 = z;
    wrreq1 = w[0]; wrreq2 = w[1]; wrreq3 = w[2];
    din1 = a; din2 = b; din3 = c;
    for (int i = 0; i < 3; i++) begin
      ne[i]   = (mq[i].size() != 0);
      head[i] = ne[i] ? mq[i][0] : 8'h00;
    end
    for (int o = 0; o < 3; o++) begin
      g[o] = 0;
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_rr[o] - 1 + k) % 3;
        if (g[o] == 0 && ne[i] && int'(head[i] >> 6) == o + 1) g[o] = i + 1;
      end
    end
    for (int i = 0; i < 3; i++)
      pop[i] = ne[i] && ((head[i] >> 6) == 8'd0 || g[0] == i + 1 || g[1] == i + 1 || g[2] == i + 1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("empty%0d", i + 1), int'(t_empty[i]), int'(!ne[i]));
      check($sformatf("full%0d", i + 1), int'(t_full[i]), int'(mq[i].size() == 4));
      check($sformatf("usedw%0d", i + 1), int'(t_usedw[i]), mq[i].size() % 4);
      check($sformatf("data%0d", i + 1), int'(t_data[i]), int'(head[i]));
      check($sformatf("rdreq%0d", i + 1), int'(t_rdreq[i]), int'(pop[i]));
      check($sformatf("sel%0d", i + 1), int'(t_sel[i]), g[i]);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
    end else begin
      for (int o = 0; o < 3; o++) begin
        m_en[o] = (g[o] != 0);
        if (g[o] != 0) begin
          m_res[o] = head[g[o] - 1];
          m_rr[o]  = g[o] % 3 + 1;
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (pop[i]) void'(mq[i].pop_front());
        acc = w[i] && (mq[i].size() < 4);
        if (acc) mq[i].push_back(din[i]);
        if (sb_on && acc) acc_cnt[din[i]]++;
      end
    end
    for (int o = 0; o < 3; o++) begin
      check($sformatf("en%0d", o + 1), int'(t_en[o]), int'(m_en[o]));
      check($sformatf("result%0d", o + 1), int'(t_res[o]), int'(m_res[o]));
      check($sformatf("hex%0d", 2 * o + 1), int'(t_hex[2 * o]), int'(seg(m_res[o][3:0])));
      check($sformatf("hex%0d", 2 * o + 2), int'(t_hex[2 * o + 1]), int'(seg(m_res[o][7:4])));
    end
    if (sb_on) begin
      if (en3) begin
        acc_cnt[result3]--;
        n_del3++;
      end
      if (full1 && usedw1 == 2'd0) saw_full1 = 1'b1;
      if (full2 && usedw2 == 2'd0) saw_full2 = 1'b1;
    end
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] w;
    logic [7:0] a, b, c;
    logic [2:0] en;
    logic [7:0] r1, r2, r3;
  } vec_t;
  vec_t tv [13];

  initial begin
    // Directed vectors with hand-derived expected registered outputs after each edge.
    tv[0]  = '{1'b0, 3'b001, 8'h41, 8'h00, 8'h00, 3'b000, 8'h00, 8'h00, 8'h00};
    tv[1]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b001, 8'h41, 8'h00, 8'h00};
    tv[2]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'h41, 8'h00, 8'h00};
    tv[3]  = '{1'b0, 3'b111, 8'h85, 8'h86, 8'h87, 3'b000, 8'h41, 8'h00, 8'h00};
    tv[4]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b010, 8'h41, 8'h85, 8'h00};
    tv[5]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b010, 8'h41, 8'h86, 8'h00};
    tv[6]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b010, 8'h41, 8'h87, 8'h00};
    tv[7]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'h41, 8'h87, 8'h00};
    tv[8]  = '{1'b0, 3'b111, 8'h81, 8'hC2, 8'h43, 3'b000, 8'h41, 8'h87, 8'h00};
    tv[9]  = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b111, 8'h43, 8'h81, 8'hC2};
    tv[10] = '{1'b0, 3'b010, 8'h00, 8'h15, 8'h00, 3'b000, 8'h43, 8'h81, 8'hC2};
    tv[11] = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'h43, 8'h81, 8'hC2};
    tv[12] = '{1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 8'h43, 8'h81, 8'hC2};
    for (int v = 0; v < 256; v++) acc_cnt[v] = 0;

    // Power-up reset and reset values.
    reset = 1'b1; data0 = 8'h00;
    wrreq1 = 1'b0; wrreq2 = 1'b0; wrreq3 = 1'b0;
    din1 = 8'h00; din2 = 8'h00; din3 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty1", int'(empty1), 1);
    check("rst_full2", int'(full2), 0);
    check("rst_usedw3", int'(usedw3), 0);
    check("rst_data1", int'(data1), 0);
    check("rst_en", int'({en1, en2, en3}), 0);
    check("rst_result2", int'(result2), 0);
    check("rst_hex1", int'(hex1), 8'hC0);
    check("rst_hex6", int'(hex6), 8'hC0);
    model_reset();

    // Table-driven directed vectors.
    for (int k = 0; k < 13; k++) begin
      cyc(tv[k].rst, tv[k].w, tv[k].a, tv[k].b, tv[k].c, 8'h00);
      check($sformatf("tv%0d_en", k), int'({en3, en2, en1}), int'(tv[k].en));
      check($sformatf("tv%0d_r1", k), int'(result1), int'(tv[k].r1));
      check($sformatf("tv%0d_r2", k), int'(result2), int'(tv[k].r2));
      check($sformatf("tv%0d_r3", k), int'(result3), int'(tv[k].r3));
      if (k == 1) begin
        check("tv1_hex1", int'(hex1), 8'hF9);
        check("tv1_hex2", int'(hex2), 8'h99);
      end
    end

    // Fill inputs 1 and 2 with dest-3 bytes every cycle; output 3 drains one per cycle.
    sb_on = 1'b1;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] bv;
      bv = 8'hC0 + 8'(k);
      cyc(1'b0, 3'b011, bv, bv, 8'h00, 8'h00);
    end
    repeat (10) cyc(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00);
    sb_on = 1'b0;
    check("full1_seen_usedw0", int'(saw_full1), 1);
    check("full2_seen_usedw0", int'(saw_full2), 1);
    check("out3_deliveries", n_del3, 15);
    begin
      int bad;
      bad = 0;
      for (int v = 0; v < 256; v++) if (acc_cnt[v] != 0) bad++;
      check("out3_exactly_once", bad, 0);
    end

    // Congest output 1 so input 1 backs up to 3 entries, then reset mid-flight.
    for (int k = 0; k < 4; k++)
      cyc(1'b0, 3'b111, 8'h50 + 8'(k), 8'h60 + 8'(k), 8'h70 + 8'(k), 8'h00);
    check("pre_rst_usedw1", int'(usedw1), 3);
    cyc(1'b1, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00);
    check("post_rst_empty1", int'(empty1), 1);
    check("post_rst_en", int'({en1, en2, en3}), 0);
    check("post_rst_hex1", int'(hex1), 8'hC0);
    check("post_rst_hex4", int'(hex4), 8'hC0);
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 3'b000, 8'h00, 8'h00, 8'h00, 8'h00);
      check("flushed_not_delivered", int'(en1 && (result1 >= 8'h51) && (result1 <= 8'h53)), 0);
    end

    // Random traffic, including discards, idle-value noise and occasional resets.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 63) == 0), 3'($urandom), 8'($urandom), 8'($urandom),
          8'($urandom), 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
